// File: rtl/alu_issue_pkg.sv
// Shared widths, FSM state encoding and command-entry layout for the ALU issue queue.
// ALU_ISSUE_CHAIN_EN adds a chain flag to each stored command entry.
package alu_issue_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
`ifdef ALU_ISSUE_CHAIN_EN
    logic              chain;
`endif
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; pushes while full and pops while empty are ignored.
// Read data is the registered head entry, so a same-cycle push into an empty FIFO is not poppable.
module alu_cmd_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == CW'(0));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Command buffer and issue sequencer in front of a fixed-latency 8-bit ALU.
// Optional build macro ALU_ISSUE_CHAIN_EN: chained commands take operand A from the last result.
module alu_issue_queue
  import alu_issue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic              cmd_chain,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [OP_W-1:0]   res_op
);

  localparam int CNT_W = $clog2(ALU_LAT + 1);

  state_t            state;
  state_t            state_nxt;
  cmd_t              push_entry;
  cmd_t              head;
  logic              full;
  logic              empty;
  logic              pop;
  logic              capture;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] issue_a;

  always_comb begin
    push_entry    = '0;
    push_entry.op = cmd_op;
    push_entry.a  = cmd_a;
    push_entry.b  = cmd_b;
`ifdef ALU_ISSUE_CHAIN_EN
    push_entry.chain = cmd_chain;
`endif
  end

  alu_cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign cmd_ready = !full;

`ifdef ALU_ISSUE_CHAIN_EN
  logic [DATA_W-1:0] acc;

  assign issue_a = head.chain ? acc : head.a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (capture) begin
      acc <= alu_out;
    end
  end
`else
  logic unused_chain;

  assign unused_chain = cmd_chain;
  assign issue_a      = head.a;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A result waiting in RESP blocks the next issue until it is handed off.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = WAIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (cnt == CNT_W'(ALU_LAT)) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end else begin
          state_nxt = WAIT;
        end
      end
      RESP: begin
        if (res_ready) begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = WAIT;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          state_nxt = RESP;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_in1 <= '0;
      alu_in2 <= '0;
      alu_op  <= '0;
      cnt     <= '0;
    end else if (pop) begin
      alu_in1 <= issue_a;
      alu_in2 <= head.b;
      alu_op  <= head.op;
      cnt     <= '0;
    end else if (state == WAIT && !capture) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // alu_op still holds the issued opcode at capture time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_op    <= '0;
    end else if (capture) begin
      res_valid <= 1'b1;
      res_data  <= alu_out;
      res_op    <= alu_op;
    end else if (state == RESP && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench: vector table, hand-written corner sequences and a randomized run
// checked against an in-order scoreboard of expected (op, in1+in2) results.
module tb_alu_issue_queue;

  localparam int DEPTH = 4;
  localparam int LAT   = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_chain;
  logic [3:0] cmd_op;
  logic [7:0] cmd_a, cmd_b;
  logic [7:0] alu_in1, alu_in2, alu_out;
  logic [3:0] alu_op;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic [3:0] res_op;

  always #5 clk = ~clk;

  alu_issue_queue #(.DEPTH(DEPTH), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_op(res_op)
  );

  // ALU stub: in1+in2 delayed through LAT register stages.
  logic [7:0] pipe [LAT];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= 8'd0;
    end else begin
      pipe[0] <= alu_in1 + alu_in2;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign alu_out = pipe[LAT-1];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: each accepted command's expected {op, result}, in acceptance order.
  logic [11:0] exp_q [$];
  logic [7:0]  model_last = 8'd0;
  logic [7:0]  last_got   = 8'd0;
  int          got_cnt    = 0;
  logic        held       = 1'b0;
  logic [7:0]  hold_data;
  logic [3:0]  hold_op;

  always @(posedge rst) begin
    exp_q.delete();
    model_last = 8'd0;
    held       = 1'b0;
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (held) begin
        check("hold_valid", res_valid, 1);
        check("hold_data", res_data, hold_data);
        check("hold_op", res_op, hold_op);
      end
      if (cmd_valid && cmd_ready) begin
        logic [7:0] ea;
        ea = cmd_a;
`ifdef ALU_ISSUE_CHAIN_EN
        if (cmd_chain) ea = model_last;
`endif
        model_last = ea + cmd_b;
        exp_q.push_back({cmd_op, model_last});
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_extra_result", 1, 0);
        end else begin
          logic [11:0] e;
          e = exp_q.pop_front();
          check("sb_data", res_data, e[7:0]);
          check("sb_op", res_op, e[11:8]);
        end
        last_got = res_data;
        got_cnt++;
      end
      held      = res_valid && !res_ready;
      hold_data = res_data;
      hold_op   = res_op;
    end
  end

  task automatic push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic ch);
    int n;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = ch; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("push_accept", (n < 300), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res(input int max, output int n);
    n = 0;
    while (!res_valid && n < max) begin
      @(negedge clk);
      n++;
    end
    check("res_timeout", res_valid, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || res_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    check("drain_idle", res_valid, 0);
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [6];
  logic rnd_done;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{4'd1,  8'd25,  8'd18,  8'd43};
    vecs[1] = '{4'd2,  8'd200, 8'd100, 8'd44};
    vecs[2] = '{4'd15, 8'd255, 8'd1,   8'd0};
    vecs[3] = '{4'd0,  8'd0,   8'd0,   8'd0};
    vecs[4] = '{4'd7,  8'd128, 8'd128, 8'd0};
    vecs[5] = '{4'd3,  8'd1,   8'd254, 8'd255};

    cmd_valid = 1'b0; cmd_chain = 1'b0; cmd_op = 4'd0; cmd_a = 8'd0; cmd_b = 8'd0;
    res_ready = 1'b1;
    rst = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_in1", alu_in1, 0);
    check("rst_in2", alu_in2, 0);
    check("rst_op", alu_op, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_op", res_op, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // Single commands from IDLE: latency, ALU drive and result.
    for (int i = 0; i < 6; i++) begin
      cmd_op = vecs[i].op; cmd_a = vecs[i].a; cmd_b = vecs[i].b; cmd_chain = 1'b0;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 1;
      while (!res_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("vec_latency", n, LAT + 3);
      check("vec_res_data", res_data, vecs[i].exp);
      check("vec_res_op", res_op, vecs[i].op);
      check("vec_alu_in1", alu_in1, vecs[i].a);
      check("vec_alu_in2", alu_in2, vecs[i].b);
      check("vec_alu_op", alu_op, vecs[i].op);
      @(negedge clk);
      check("vec_valid_clear", res_valid, 0);
    end

    // Backpressure: one result held, four queued fill the FIFO, the next is stalled.
    res_ready = 1'b0;
    push(4'd1, 8'd1, 8'd2, 1'b0);
    wait_res(20, n);
    push(4'd2, 8'd3, 8'd4, 1'b0);
    push(4'd3, 8'd5, 8'd6, 1'b0);
    push(4'd4, 8'd7, 8'd8, 1'b0);
    check("bp_ready_3", cmd_ready, 1);
    push(4'd5, 8'd9, 8'd10, 1'b0);
    check("bp_full", cmd_ready, 0);
    cmd_op = 4'd6; cmd_a = 8'd11; cmd_b = 8'd12; cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_stalled", cmd_ready, 0);
      check("bp_res_held", res_data, 3);
    end
    res_ready = 1'b1;
    push(4'd6, 8'd11, 8'd12, 1'b0);
    drain();

    // Asynchronous reset while WAIT is in progress with two entries queued.
    push(4'd9, 8'd50, 8'd60, 1'b0);
    push(4'd10, 8'd70, 8'd80, 1'b0);
    push(4'd11, 8'd90, 8'd91, 1'b0);
    check("pre_rst_in1", alu_in1, 50);
    check("pre_rst_busy", cmd_ready && !res_valid, 1);
    rst = 1'b1;
    #1;
    check("arst_in1", alu_in1, 0);
    check("arst_in2", alu_in2, 0);
    check("arst_op", alu_op, 0);
    check("arst_res_valid", res_valid, 0);
    check("arst_res_data", res_data, 0);
    check("arst_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_no_stale", res_valid, 0);
    push(4'd12, 8'd33, 8'd44, 1'b0);
    drain();
    check("post_rst_result", last_got, 77);

    // Chained command: operand A from the previous result only in the chain build.
    push(4'd4, 8'd10, 8'd5, 1'b0);
    push(4'd4, 8'd99, 8'd7, 1'b1);
    drain();
`ifdef ALU_ISSUE_CHAIN_EN
    check("chain_result", last_got, 22);
`else
    check("chain_result", last_got, 106);
`endif

    // Random commands with a randomly stalling consumer.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 50; i++) begin
          push(4'($urandom_range(15)), 8'($urandom_range(255)), 8'($urandom_range(255)),
               1'($urandom_range(1)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk);
          res_ready = 1'($urandom_range(1));
        end
      end
    join
    res_ready = 1'b1;
    drain();
    check("total_results", got_cnt, 65);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
